systolic1_ctrl: RTL and testbench
=================================

SYSTOLIC1_CTRL -- requirements
Module: systolic1_ctrl

Interface
REQ-001 Parameter LEN, default 784: number of image words in one job; legal range 1 to 2^ADDR_W.
REQ-002 Parameter ADDR_W, default 10: width of pix_idx.
REQ-003 Parameter DRAIN_CYC, default 2: number of cycles between the last accepted word and the end of the job; legal range 1 to 15.
REQ-004 Port list, one per line:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- go  in  1  job request; sampled only in IDLE.
- img_valid  in  1  image word available.
- img_data  in  32  image word.
- img_ready  out  1  controller accepts an image word this cycle.
- image  out  32  registered word driven to the MAC array.
- pix_idx  out  ADDR_W  registered index of the word on image; used as the weight-memory address.
- mac_start  out  1  one-cycle pulse that clears all MAC accumulators.
- mac_stop  out  1  one-cycle pulse that freezes all MAC results.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  MAC results p0..p31 are final and held.
- res_ready  in  1  consumer has taken the results.
- done  out  1  one-cycle pulse when a job retires.

Function
REQ-005 The FSM SHALL have the states IDLE, CLEAR, STREAM, DRAIN and HOLD.
REQ-006 IDLE: when go=1, the next state SHALL be CLEAR; otherwise the FSM stays in IDLE.
REQ-007 CLEAR SHALL last exactly 1 cycle:
- mac_start=1, image=0, word counter cleared to 0.
- Next state: STREAM.
REQ-008 STREAM SHALL drive img_ready=1; a word is accepted in any cycle where img_valid=1 and img_ready=1.
REQ-009 On acceptance, at the next edge:
- image SHALL load img_data.
- pix_idx SHALL load the counter value.
- The counter SHALL increment.
REQ-010 In any STREAM cycle without acceptance (bubble), at the next edge:
- image SHALL load 0, so the accumulation is unchanged.
- pix_idx SHALL hold.
- The counter SHALL hold.
REQ-011 Acceptance with counter = LEN-1 SHALL move the FSM to DRAIN; the counter SHALL never wrap within a job.
REQ-012 DRAIN SHALL last exactly DRAIN_CYC cycles:
- img_ready=0 and image loads 0.
- mac_stop=1 only in the final DRAIN cycle.
- Next state: HOLD.
REQ-013 HOLD SHALL drive res_valid=1 until a cycle with res_ready=1. In that cycle done=1 for one cycle, and the FSM returns to IDLE at the next edge.
REQ-014 go SHALL be ignored in every state except IDLE, including in a HOLD cycle where res_ready=1. A go in the first IDLE cycle after HOLD SHALL be accepted.
REQ-015 img_ready SHALL be 0 outside STREAM. img_valid outside STREAM SHALL have no effect.
REQ-016 mac_start and mac_stop SHALL never both be 1 in the same cycle; each SHALL pulse exactly once per job.
REQ-017 Latency with no bubbles, measuring go sampled in cycle 0:
- mac_start in cycle 1.
- Words accepted in cycles 2..LEN+1.
- mac_stop in cycle LEN+1+DRAIN_CYC.
- res_valid from cycle LEN+2+DRAIN_CYC.
- Each bubble adds 1 cycle to every event after it.
REQ-018 With LEN=1, the FSM SHALL enter DRAIN directly after the single accepted word.

Reset
REQ-019 rst=1 at a rising edge SHALL force IDLE from any state and clear the counter. At that edge the outputs SHALL take these values:
- image=0, pix_idx=0.
- img_ready=0, mac_start=0, mac_stop=0.
- busy=0, res_valid=0, done=0.
REQ-020 Reset SHALL take priority over go, img_valid and res_ready in the same cycle.
REQ-021 A job interrupted by reset SHALL not issue mac_stop or done. The next job SHALL start with CLEAR (mac_start).

Verification
REQ-022 LEN=4, DRAIN_CYC=2, go in cycle 0, img_valid held 1 with data 1,2,3,4:
- mac_start in cycle 1.
- pix_idx 0..3 with image 1..4 in cycles 3..6.
- mac_stop in cycle 7.
- res_valid from cycle 8.
- res_ready=1 in cycle 10 gives done in cycle 10 and IDLE in cycle 11.
REQ-023 Same configuration with img_valid=0 in cycle 3 only:
- image=0 in the cycle after the bubble, with pix_idx held.
- mac_stop in cycle 8; res_valid from cycle 9.
REQ-024 go=1 held continuously from cycle 0: exactly one mac_start per job. The second job's CLEAR is the cycle after the IDLE that follows done.
REQ-025 rst=1 in cycle 4 of a running job: every output is at its reset value from cycle 5, with no mac_stop and no done. A go in cycle 6 gives mac_start in cycle 7.
REQ-026 LEN=1, DRAIN_CYC=1, go in cycle 0, word accepted in cycle 2: mac_stop in cycle 3, res_valid from cycle 4.
REQ-027 res_ready held 0 for 100 cycles in HOLD: res_valid stays 1, busy stays 1, and go and img_valid pulses are ignored.

Source files
------------

// File: rtl/systolic1_ctrl.sv
// Job controller for a 32-lane systolic MAC row: clears the accumulators, streams LEN image
// words with their weight addresses, drains the array, then holds results until the consumer takes them.
module systolic1_ctrl #(
   parameter int LEN       = 784,
   parameter int ADDR_W    = 10,
   parameter int DRAIN_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic              img_valid,
   input  logic [31:0]       img_data,
   output logic              img_ready,
   output logic [31:0]       image,
   output logic [ADDR_W-1:0] pix_idx,
   output logic              mac_start,
   output logic              mac_stop,
   output logic              busy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(LEN - 1);
   localparam logic [3:0]        DRAIN_LAST = 4'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, HOLD} state_t;

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [3:0]        dcnt;
   logic              accept;

   assign accept = img_valid & img_ready;
   // done is tied to the handshake cycle itself, so it cannot be registered; reset masks it.
   assign done   = res_valid & res_ready & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         dcnt      <= '0;
         image     <= '0;
         pix_idx   <= '0;
         img_ready <= 1'b0;
         mac_start <= 1'b0;
         mac_stop  <= 1'b0;
         busy      <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  state     <= CLEAR;
                  mac_start <= 1'b1;
                  busy      <= 1'b1;
                  image     <= '0;
                  cnt       <= '0;
               end
            end
            CLEAR: begin
               state     <= STREAM;
               mac_start <= 1'b0;
               img_ready <= 1'b1;
               cnt       <= '0;
            end
            STREAM: begin
               // A bubble feeds zero so the accumulators see no contribution.
               if (accept) begin
                  image   <= img_data;
                  pix_idx <= cnt;
                  if (cnt == LAST_IDX) begin
                     state     <= DRAIN;
                     img_ready <= 1'b0;
                     dcnt      <= '0;
                     mac_stop  <= (DRAIN_LAST == 4'd0);
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  image <= '0;
               end
            end
            DRAIN: begin
               image <= '0;
               if (dcnt == DRAIN_LAST) begin
                  state     <= HOLD;
                  mac_stop  <= 1'b0;
                  res_valid <= 1'b1;
               end else begin
                  dcnt     <= dcnt + 4'd1;
                  mac_stop <= ((dcnt + 4'd1) == DRAIN_LAST);
               end
            end
            HOLD: begin
               if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic1_ctrl.sv
// Directed bench for systolic1_ctrl: a LEN=4/DRAIN_CYC=2 instance for the main scenarios
// and a LEN=1/DRAIN_CYC=1 instance for the single-word job.
module tb_systolic1_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        go, img_valid, res_ready;
   logic [31:0] img_data;
   logic        img_ready, mac_start, mac_stop, busy, res_valid, done;
   logic [31:0] image;
   logic [9:0]  pix_idx;

   logic        go2, img_valid2, res_ready2;
   logic [31:0] img_data2;
   logic        img_ready2, mac_start2, mac_stop2, busy2, res_valid2, done2;
   logic [31:0] image2;
   logic [9:0]  pix_idx2;

   logic [47:0] obs1, obs2;
   int          n_checks = 0;
   int          n_pass   = 0;

   // Field order: mac_start, mac_stop, img_ready, busy, res_valid, done, pix_idx, image.
   localparam logic [47:0] PMASK = ~(48'h3FF << 32);

   always #5 clk = ~clk;

   systolic1_ctrl #(.LEN(4), .ADDR_W(10), .DRAIN_CYC(2)) dut (
      .clk(clk), .rst(rst), .go(go), .img_valid(img_valid), .img_data(img_data),
      .img_ready(img_ready), .image(image), .pix_idx(pix_idx), .mac_start(mac_start),
      .mac_stop(mac_stop), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
      .done(done));

   systolic1_ctrl #(.LEN(1), .ADDR_W(10), .DRAIN_CYC(1)) dut1 (
      .clk(clk), .rst(rst), .go(go2), .img_valid(img_valid2), .img_data(img_data2),
      .img_ready(img_ready2), .image(image2), .pix_idx(pix_idx2), .mac_start(mac_start2),
      .mac_stop(mac_stop2), .busy(busy2), .res_valid(res_valid2), .res_ready(res_ready2),
      .done(done2));

   assign obs1 = {mac_start, mac_stop, img_ready, busy, res_valid, done, pix_idx, image};
   assign obs2 = {mac_start2, mac_stop2, img_ready2, busy2, res_valid2, done2, pix_idx2, image2};

   // Expected outputs at cycle r after go for a bubble-free LEN=4 job with data 1..4,
   // where res_ready is first seen in cycle rdy.
   function automatic logic [47:0] exp_nb(int r, int rdy);
      logic [9:0]  p;
      logic [31:0] d;
      p = (r >= 6) ? 10'd3 : ((r >= 3) ? 10'(r - 3) : 10'd0);
      d = (r >= 3 && r <= 6) ? 32'(r - 2) : 32'd0;
      return {(r == 1), (r == 7), (r >= 2 && r <= 5), (r >= 1 && r <= rdy),
              (r >= 8 && r <= rdy), (r == rdy), p, d};
   endfunction

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         rst = 1'b1; go = 1'b1; img_valid = 1'b1; res_ready = 1'b1; img_data = 32'hFFFF_FFFF;
         go2 = 1'b1; img_valid2 = 1'b1; res_ready2 = 1'b1; img_data2 = 32'hFFFF_FFFF;
         @(posedge clk); #1;
         n_checks++;
         if (obs1 !== 48'd0) $display("FAIL reset dut c=%0d: got %h expected %h", c, obs1, 48'd0);
         else n_pass++;
         n_checks++;
         if (obs2 !== 48'd0) $display("FAIL reset dut1 c=%0d: got %h expected %h", c, obs2, 48'd0);
         else n_pass++;
      end
      rst = 1'b0; go = 1'b0; img_valid = 1'b0; res_ready = 1'b0; img_data = '0;
      go2 = 1'b0; img_valid2 = 1'b0; res_ready2 = 1'b0; img_data2 = '0;
      for (int c = 0; c < 2; c++) begin
         #2;
         n_checks++;
         if (obs1 !== 48'd0) $display("FAIL idle c=%0d: got %h expected %h", c, obs1, 48'd0);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stream();
      logic [47:0] e;
      for (int c = 0; c <= 11; c++) begin
         go        = (c == 0);
         img_valid = 1'b1;
         img_data  = (c >= 2 && c <= 5) ? 32'(c - 1) : 32'hDEAD_0000 + 32'(c);
         res_ready = (c == 10);
         #2;
         e = exp_nb(c, 10);
         n_checks++;
         if (c < 3) begin
            if ((obs1 & PMASK) !== (e & PMASK)) $display("FAIL stream c=%0d: got %h expected %h", c, obs1 & PMASK, e & PMASK);
            else n_pass++;
         end else begin
            if (obs1 !== e) $display("FAIL stream c=%0d: got %h expected %h", c, obs1, e);
            else n_pass++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_bubble();
      logic [47:0] e;
      logic [31:0] d;
      logic [9:0]  p;
      for (int c = 0; c <= 10; c++) begin
         go        = (c == 0);
         img_valid = (c != 3);
         img_data  = (c == 2) ? 32'd1 : ((c >= 4 && c <= 6) ? 32'(c - 2) : 32'h0000_0BAD);
         res_ready = (c == 9);
         #2;
         case (c)
            3: begin d = 32'd1; p = 10'd0; end
            4: begin d = 32'd0; p = 10'd0; end
            5: begin d = 32'd2; p = 10'd1; end
            6: begin d = 32'd3; p = 10'd2; end
            7: begin d = 32'd4; p = 10'd3; end
            default: begin d = 32'd0; p = (c > 7) ? 10'd3 : 10'd0; end
         endcase
         e = {(c == 1), (c == 8), (c >= 2 && c <= 6), (c >= 1 && c <= 9), (c == 9), (c == 9), p, d};
         n_checks++;
         if (c < 3) begin
            if ((obs1 & PMASK) !== (e & PMASK)) $display("FAIL bubble c=%0d: got %h expected %h", c, obs1 & PMASK, e & PMASK);
            else n_pass++;
         end else begin
            if (obs1 !== e) $display("FAIL bubble c=%0d: got %h expected %h", c, obs1, e);
            else n_pass++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [47:0] e;
      for (int c = 0; c <= 19; c++) begin
         go        = (c <= 9);
         img_valid = 1'b1;
         img_data  = 32'(c);
         res_ready = 1'b1;
         #2;
         e = (c <= 8) ? exp_nb(c, 8) : exp_nb(c - 9, 8);
         n_checks++;
         if (obs1[47:42] !== e[47:42]) $display("FAIL back_to_back c=%0d: got %b expected %b", c, obs1[47:42], e[47:42]);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_midjob();
      logic [47:0] e;
      for (int c = 0; c <= 15; c++) begin
         rst       = (c == 4);
         go        = (c == 0 || c == 6);
         img_valid = 1'b1;
         img_data  = (c < 7) ? 32'(c - 1) : 32'(c - 7);
         res_ready = (c == 14);
         #2;
         if (c <= 4)      e = exp_nb(c, 99);
         else if (c <= 6) e = 48'd0;
         else             e = exp_nb(c - 6, 8);
         n_checks++;
         if (c < 3 || c == 7 || c == 8) begin
            if ((obs1 & PMASK) !== (e & PMASK)) $display("FAIL reset_midjob c=%0d: got %h expected %h", c, obs1 & PMASK, e & PMASK);
            else n_pass++;
         end else begin
            if (obs1 !== e) $display("FAIL reset_midjob c=%0d: got %h expected %h", c, obs1, e);
            else n_pass++;
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
   endtask

   task automatic test_hold();
      logic [47:0] e;
      for (int c = 0; c <= 109; c++) begin
         go        = (c == 0) || (c >= 8 && c <= 108 && (c % 2 == 1)) || (c == 108);
         img_valid = (c < 8) ? 1'b1 : ((c % 4) >= 2);
         img_data  = (c >= 2 && c <= 5) ? 32'(c - 1) : $urandom;
         res_ready = (c == 108);
         #2;
         e = exp_nb(c, 108);
         n_checks++;
         if (c < 3) begin
            if ((obs1 & PMASK) !== (e & PMASK)) $display("FAIL hold c=%0d: got %h expected %h", c, obs1 & PMASK, e & PMASK);
            else n_pass++;
         end else begin
            if (obs1 !== e) $display("FAIL hold c=%0d: got %h expected %h", c, obs1, e);
            else n_pass++;
         end
         @(posedge clk); #1;
      end
      go = 1'b0; img_valid = 1'b0; res_ready = 1'b0;
   endtask

   task automatic test_len1();
      logic [47:0] e;
      for (int c = 0; c <= 6; c++) begin
         go2        = (c == 0);
         img_valid2 = 1'b1;
         img_data2  = 32'd100 + 32'(c);
         res_ready2 = (c == 5);
         #2;
         e = {(c == 1), (c == 3), (c == 2), (c >= 1 && c <= 5), (c == 4 || c == 5), (c == 5),
              10'd0, (c == 3) ? 32'd102 : 32'd0};
         n_checks++;
         if (c < 3) begin
            if ((obs2 & PMASK) !== (e & PMASK)) $display("FAIL len1 c=%0d: got %h expected %h", c, obs2 & PMASK, e & PMASK);
            else n_pass++;
         end else begin
            if (obs2 !== e) $display("FAIL len1 c=%0d: got %h expected %h", c, obs2, e);
            else n_pass++;
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_bubble();
      test_back_to_back();
      test_reset_midjob();
      test_hold();
      test_len1();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
